// File: rtl/filter_chan_sched_pkg.sv
// Shared types and helpers for the FIR engine channel scheduler.
package filter_sched_pkg;

  // Largest channel count the round-robin picker is sized for.
  localparam int unsigned MaxCh = 8;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StIssue,
    StWaitRes,
    StDeliver
  } sched_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First pending channel at or after ptr, wrapping modulo num_ch.
  function automatic rr_pick_t rr_pick(input logic [MaxCh-1:0] pending,
                                       input logic [2:0]       ptr,
                                       input int unsigned      num_ch);
    rr_pick_t    res;
    int unsigned c;
    res = '0;
    for (int unsigned i = 0; i < MaxCh; i++) begin
      c = (int'(ptr) + i) % num_ch;
      if ((i < num_ch) && !res.found && pending[c]) begin
        res.found = 1'b1;
        res.idx   = c[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/filter_chan_sched_chan_in_buf.sv
// Single-entry sample holding register for one channel.
module chan_in_buf
  import filter_sched_pkg::*;
#(
  parameter int unsigned DATA_W = 24
) (
  input  logic              pi_clk,
  input  logic              pi_sreset,
  input  logic              pi_en,
  input  logic              pi_s_tvalid,
  input  logic [DATA_W-1:0] pi_s_tdata,
  input  logic              pi_s_tlast,
  output logic              po_s_tready,
  input  logic              pi_clr,
  output logic              po_valid,
  output logic [DATA_W-1:0] po_data,
  output logic              po_last
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              accept;

  // Ready only from registered state; held low while reset is asserted.
  assign po_s_tready = pi_en & ~valid_q & ~pi_sreset;
  assign accept      = po_s_tready & pi_s_tvalid;

  assign po_valid = valid_q;
  assign po_data  = data_q;
  assign po_last  = last_q;

  // Capture on handshake; scheduler clears once the engine takes the sample.
  always_ff @(posedge pi_clk or posedge pi_sreset) begin
    if (pi_sreset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= pi_s_tdata;
      last_q  <= pi_s_tlast;
    end else if (pi_clr) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/filter_chan_sched.sv
// Round-robin scheduler sharing one FIR engine between NUM_CH channels.
module filter_chan_sched
  import filter_sched_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     pi_clk,
  input  logic                     pi_sreset,
  input  logic [NUM_CH-1:0]        pi_ch_en,
  input  logic [NUM_CH-1:0]        pi_s_tvalid,
  input  logic [NUM_CH*DATA_W-1:0] pi_s_tdata,
  input  logic [NUM_CH-1:0]        pi_s_tlast,
  output logic [NUM_CH-1:0]        po_s_tready,
  output logic                     po_f_tvalid,
  output logic [DATA_W-1:0]        po_f_tdata,
  output logic                     po_f_tlast,
  input  logic                     pi_f_tready,
  output logic [ChW-1:0]           po_ch_sel,
  input  logic                     pi_r_tvalid,
  input  logic [DATA_W-1:0]        pi_r_tdata,
  output logic                     po_r_tready,
  output logic [NUM_CH-1:0]        po_m_tvalid,
  output logic [DATA_W-1:0]        po_m_tdata,
  output logic                     po_m_tlast,
  input  logic [NUM_CH-1:0]        pi_m_tready,
  output logic                     po_busy,
  output logic                     po_err,
  output logic [ChW-1:0]           po_err_ch
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ChW-1:0] LastCh  = ChW'(NUM_CH - 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT - 1);

  logic [NUM_CH-1:0] hold_valid;
  logic [DATA_W-1:0] hold_data [NUM_CH];
  logic [NUM_CH-1:0] hold_last;
  logic [NUM_CH-1:0] buf_clr;

  sched_state_t      state_q;
  logic [ChW-1:0]    cur_ch_q;
  logic [ChW-1:0]    rr_q;
  logic [WdW-1:0]    wd_q;
  logic              f_tvalid_q;
  logic [DATA_W-1:0] f_tdata_q;
  logic              f_tlast_q;
  logic              r_tready_q;
  logic [NUM_CH-1:0] m_tvalid_q;
  logic [DATA_W-1:0] m_tdata_q;
  logic              m_tlast_q;
  logic              busy_q;
  logic              err_q;
  logic [ChW-1:0]    err_ch_q;

  logic [MaxCh-1:0]  pend_ext;
  logic [2:0]        ptr_ext;
  rr_pick_t          pick;
  logic [ChW-1:0]    grant;
  logic [ChW-1:0]    nxt_ch;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_buf
    chan_in_buf #(
      .DATA_W(DATA_W)
    ) u_buf (
      .pi_clk     (pi_clk),
      .pi_sreset  (pi_sreset),
      .pi_en      (pi_ch_en[c]),
      .pi_s_tvalid(pi_s_tvalid[c]),
      .pi_s_tdata (pi_s_tdata[c*DATA_W +: DATA_W]),
      .pi_s_tlast (pi_s_tlast[c]),
      .po_s_tready(po_s_tready[c]),
      .pi_clr     (buf_clr[c]),
      .po_valid   (hold_valid[c]),
      .po_data    (hold_data[c]),
      .po_last    (hold_last[c])
    );
  end

  // Round-robin search over pending buffers, starting at the pointer.
  always_comb begin
    pend_ext               = '0;
    pend_ext[NUM_CH-1:0]   = hold_valid;
    ptr_ext                = 3'(rr_q);
    pick                   = rr_pick(pend_ext, ptr_ext, NUM_CH);
    grant                  = ChW'(pick.idx);
    nxt_ch                 = (cur_ch_q == LastCh) ? '0 : cur_ch_q + 1'b1;
  end

  // Release the granted buffer on the engine handshake only.
  always_comb begin
    buf_clr = '0;
    if ((state_q == StIssue) && pi_f_tready) begin
      buf_clr[cur_ch_q] = 1'b1;
    end
  end

  // Scheduler FSM with all engine/channel outputs registered.
  always_ff @(posedge pi_clk or posedge pi_sreset) begin
    if (pi_sreset) begin
      state_q    <= StIdle;
      cur_ch_q   <= '0;
      rr_q       <= '0;
      wd_q       <= '0;
      f_tvalid_q <= 1'b0;
      f_tdata_q  <= '0;
      f_tlast_q  <= 1'b0;
      r_tready_q <= 1'b0;
      m_tvalid_q <= '0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|hold_valid) begin
            state_q <= StArb;
            busy_q  <= 1'b1;
          end
        end
        StArb: begin
          if (pick.found) begin
            cur_ch_q   <= grant;
            f_tvalid_q <= 1'b1;
            f_tdata_q  <= hold_data[grant];
            f_tlast_q  <= hold_last[grant];
            state_q    <= StIssue;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StIssue: begin
          // No watchdog here: the engine may stall its input indefinitely.
          if (pi_f_tready) begin
            f_tvalid_q <= 1'b0;
            m_tlast_q  <= hold_last[cur_ch_q];
            wd_q       <= '0;
            r_tready_q <= 1'b1;
            state_q    <= StWaitRes;
          end
        end
        StWaitRes: begin
          // A result on the expiry cycle wins over the timeout.
          if (pi_r_tvalid) begin
            m_tdata_q  <= pi_r_tdata;
            r_tready_q <= 1'b0;
            m_tvalid_q <= NUM_CH'(1) << cur_ch_q;
            state_q    <= StDeliver;
          end else if (wd_q == WdLimit) begin
            err_q      <= 1'b1;
            err_ch_q   <= cur_ch_q;
            rr_q       <= nxt_ch;
            r_tready_q <= 1'b0;
            state_q    <= StArb;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        StDeliver: begin
          if (pi_m_tready[cur_ch_q]) begin
            m_tvalid_q <= '0;
            rr_q       <= nxt_ch;
            state_q    <= StArb;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign po_f_tvalid = f_tvalid_q;
  assign po_f_tdata  = f_tdata_q;
  assign po_f_tlast  = f_tlast_q;
  assign po_ch_sel   = cur_ch_q;
  assign po_r_tready = r_tready_q;
  assign po_m_tvalid = m_tvalid_q;
  assign po_m_tdata  = m_tdata_q;
  assign po_m_tlast  = m_tlast_q;
  assign po_busy     = busy_q;
  assign po_err      = err_q;
  assign po_err_ch   = err_ch_q;

endmodule

// File: tb/tb_filter_chan_sched.sv
// Bench for filter_chan_sched: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model.
module tb_filter_chan_sched;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 24;
  localparam int unsigned TO  = 16;
  localparam int unsigned CW  = 1;

  localparam int PIdle = 0, PArb = 1, PIssue = 2, PWait = 3, PDel = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tlast;
  logic [NCH-1:0]    s_tready;
  logic              f_tvalid;
  logic [DW-1:0]     f_tdata;
  logic              f_tlast;
  logic              f_tready;
  logic [CW-1:0]     ch_sel;
  logic              r_tvalid;
  logic [DW-1:0]     r_tdata;
  logic              r_tready;
  logic [NCH-1:0]    m_tvalid;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic [NCH-1:0]    m_tready;
  logic              busy;
  logic              err;
  logic [CW-1:0]     err_ch;

  always #5 clk = ~clk;

  filter_chan_sched #(
    .NUM_CH (NCH),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .pi_clk     (clk),
    .pi_sreset  (rst),
    .pi_ch_en   (ch_en),
    .pi_s_tvalid(s_tvalid),
    .pi_s_tdata (s_tdata),
    .pi_s_tlast (s_tlast),
    .po_s_tready(s_tready),
    .po_f_tvalid(f_tvalid),
    .po_f_tdata (f_tdata),
    .po_f_tlast (f_tlast),
    .pi_f_tready(f_tready),
    .po_ch_sel  (ch_sel),
    .pi_r_tvalid(r_tvalid),
    .pi_r_tdata (r_tdata),
    .po_r_tready(r_tready),
    .po_m_tvalid(m_tvalid),
    .po_m_tdata (m_tdata),
    .po_m_tlast (m_tlast),
    .pi_m_tready(m_tready),
    .po_busy    (busy),
    .po_err     (err),
    .po_err_ch  (err_ch)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: per-channel slot, one job in flight.
  bit            mv [NCH];
  logic [DW-1:0] md [NCH];
  bit            ml [NCH];
  int            ph, mch, mrr, waited, merr_ch;
  logic [DW-1:0] mres;
  bit            mlast, merr;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mv[c] = 0; md[c] = '0; ml[c] = 0;
    end
    ph = PIdle; mch = 0; mrr = 0; waited = 0; merr_ch = 0;
    mres = '0; mlast = 0; merr = 0;
  endtask

  task automatic model_step();
    bit acc [NCH];
    bit any;
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    any = 0;
    for (int c = 0; c < NCH; c++) begin
      acc[c] = s_tvalid[c] && ch_en[c] && !mv[c];
      any |= mv[c];
    end
    merr = 0;
    case (ph)
      PIdle: if (any) ph = PArb;
      PArb: begin
        g = -1;
        for (int k = 0; k < NCH; k++)
          if (g < 0 && mv[(mrr + k) % NCH]) g = (mrr + k) % NCH;
        if (g >= 0) begin
          mch = g;
          ph  = PIssue;
        end else ph = PIdle;
      end
      PIssue: if (f_tready) begin
        mv[mch] = 0; mlast = ml[mch]; waited = 0; ph = PWait;
      end
      PWait: begin
        if (r_tvalid) begin
          mres = r_tdata; ph = PDel;
        end else begin
          waited++;
          if (waited == TO) begin
            merr = 1; merr_ch = mch; mrr = (mch + 1) % NCH; ph = PArb;
          end
        end
      end
      PDel: if (m_tready[mch]) begin
        mrr = (mch + 1) % NCH; ph = PArb;
      end
      default: ph = PIdle;
    endcase
    for (int c = 0; c < NCH; c++)
      if (acc[c]) begin
        mv[c] = 1; md[c] = s_tdata[c*DW +: DW]; ml[c] = s_tlast[c];
      end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] exp_rdy;
    logic [NCH-1:0] exp_mv;
    for (int c = 0; c < NCH; c++) exp_rdy[c] = !rst && ch_en[c] && !mv[c];
    exp_mv = (ph == PDel) ? (NCH'(1) << mch) : '0;
    check("s_tready", 32'(s_tready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(ph != PIdle));
    check("f_tvalid", 32'(f_tvalid), 32'(ph == PIssue));
    check("ch_sel", 32'(ch_sel), 32'(mch));
    check("r_tready", 32'(r_tready), 32'(ph == PWait));
    check("m_tvalid", 32'(m_tvalid), 32'(exp_mv));
    check("err", 32'(err), 32'(merr));
    check("err_ch", 32'(err_ch), 32'(merr_ch));
    if (ph == PIssue) begin
      check("f_tdata", 32'(f_tdata), 32'(md[mch]));
      check("f_tlast", 32'(f_tlast), 32'(ml[mch]));
    end
    if (ph == PDel) begin
      check("m_tdata", 32'(m_tdata), 32'(mres));
      check("m_tlast", 32'(m_tlast), 32'(mlast));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    ch_en = '1; s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    f_tready = 0; r_tvalid = 0; r_tdata = '0; m_tready = '0;
  endtask

  task automatic wait_mvalid(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (m_tvalid != '0) begin
        ok = 1;
        return;
      end
      tick();
    end
    ok = (m_tvalid != '0);
  endtask

  bit ok;
  int order [8];
  int n_grant;
  int mode;

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    rst = 0;

    // Single transaction: accept, engine latency 5, result to ch0.
    s_tvalid = 2'b01; s_tdata[0 +: DW] = 24'h000123; f_tready = 1;
    tick();
    s_tvalid = '0;
    tick(); tick();
    check("t1_f_tvalid", 32'(f_tvalid), 32'd1);
    check("t1_f_tdata", 32'(f_tdata), 32'h000123);
    check("t1_ch_sel", 32'(ch_sel), 32'd0);
    repeat (5) tick();
    check("t1_no_early_valid", 32'(m_tvalid), 32'd0);
    r_tvalid = 1; r_tdata = 24'h000456;
    tick();
    r_tvalid = 0;
    check("t1_m_tvalid", 32'(m_tvalid), 32'b01);
    check("t1_m_tdata", 32'(m_tdata), 32'h000456);

    // Backpressure on ch0 while ch1 arrives.
    s_tvalid = 2'b10; s_tdata[DW +: DW] = 24'h000abc;
    tick();
    s_tvalid = '0;
    check("t4_ch1_held", 32'(s_tready[1]), 32'd0);
    repeat (19) tick();
    check("t4_m_tvalid_stable", 32'(m_tvalid), 32'b01);
    check("t4_m_tdata_stable", 32'(m_tdata), 32'h000456);
    m_tready = 2'b01;
    tick();
    m_tready = '0; f_tready = 1; r_tvalid = 1; r_tdata = 24'h000789;
    wait_mvalid(20, ok);
    check("t4_ch1_served", 32'(ok), 32'd1);
    check("t4_ch1_m_tvalid", 32'(m_tvalid), 32'b10);
    check("t4_ch1_m_tdata", 32'(m_tdata), 32'h000789);
    m_tready = 2'b10;
    tick();
    idle_inputs();
    repeat (3) tick();

    // Channel 0 disabled, channel 1 carries tlast.
    ch_en = 2'b10; s_tvalid = 2'b11; s_tlast = 2'b10;
    s_tdata = {24'h00beef, 24'h00dead};
    tick();
    check("t5_ch0_not_ready", 32'(s_tready[0]), 32'd0);
    s_tvalid = '0;
    repeat (2) tick();
    check("t5_f_tlast", 32'(f_tlast), 32'd1);
    check("t5_ch_sel", 32'(ch_sel), 32'd1);
    f_tready = 1; r_tvalid = 1; r_tdata = 24'h000042;
    wait_mvalid(20, ok);
    check("t5_served", 32'(ok), 32'd1);
    check("t5_m_tvalid", 32'(m_tvalid), 32'b10);
    check("t5_m_tlast", 32'(m_tlast), 32'd1);
    m_tready = 2'b11;
    tick();
    idle_inputs();
    repeat (3) tick();
    check("t5_back_idle", 32'(busy), 32'd0);

    // Watchdog: engine takes the sample but never answers.
    s_tvalid = 2'b01; s_tdata[0 +: DW] = 24'h000777; f_tready = 1;
    tick();
    s_tvalid = '0;
    repeat (18) tick();
    check("t3_no_err_early", 32'(err), 32'd0);
    tick();
    check("t3_err_pulse", 32'(err), 32'd1);
    check("t3_err_ch", 32'(err_ch), 32'd0);
    tick();
    check("t3_err_one_cycle", 32'(err), 32'd0);
    s_tvalid = 2'b10; s_tdata[DW +: DW] = 24'h000111; r_tvalid = 1; r_tdata = 24'h000222;
    tick();
    s_tvalid = '0;
    wait_mvalid(20, ok);
    check("t3_next_served", 32'(ok), 32'd1);
    check("t3_next_m_tvalid", 32'(m_tvalid), 32'b10);
    m_tready = 2'b11;
    tick();
    idle_inputs();
    repeat (3) tick();

    // Async reset in the middle of a wait for a result.
    s_tvalid = 2'b01; f_tready = 1;
    tick();
    s_tvalid = 2'b10;
    repeat (5) tick();
    s_tvalid = '0;
    #2 rst = 1;
    #1 model_reset();
    compare_all();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_r_tready", 32'(r_tready), 32'd0);
    check("t6_s_tready", 32'(s_tready), 32'd0);
    repeat (2) tick();
    rst = 0;
    idle_inputs();
    tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_buffers_empty", 32'(s_tready), 32'b11);

    // Fairness: both channels pending at reset release.
    rst = 1;
    s_tvalid = 2'b11; f_tready = 1; r_tvalid = 1; m_tready = 2'b11;
    tick();
    rst = 0;
    n_grant = 0;
    for (int i = 0; i < 200 && n_grant < 8; i++) begin
      s_tdata = {$urandom_range(0, 255) > 0 ? 24'($urandom) : 24'h0, 24'($urandom)};
      if (f_tvalid && f_tready) begin
        order[n_grant] = int'(ch_sel);
        n_grant++;
      end
      tick();
    end
    check("t2_grant_count", 32'(n_grant), 32'd8);
    for (int i = 0; i < 8; i++) check("t2_grant_order", 32'(order[i]), 32'(i % 2));
    idle_inputs();

    // Randomized traffic, with result-rate modes that force timeouts.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      if ($urandom_range(0, 49) == 0) ch_en = NCH'($urandom);
      s_tvalid = NCH'($urandom);
      s_tlast  = NCH'($urandom);
      s_tdata  = {24'($urandom), 24'($urandom)};
      f_tready = ($urandom_range(0, 9) < 7);
      r_tvalid = (mode == 0) ? ($urandom_range(0, 9) < 3) : (mode == 2);
      r_tdata  = 24'($urandom);
      m_tready = NCH'($urandom);
      rst      = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_chan_sched.md
Name: filter_chan_sched

Overview:
Round-robin scheduler that time-shares one FIR filter engine (coefficient bank select plus AXI-Stream sample in/result out) between NUM_CH audio channels.
- Each channel has its own slave input stream and master output stream.
- The scheduler buffers one sample per channel, grants the engine to one channel at a time and steers the engine's coefficient bank.
- It returns the result to the owning channel and polices engine latency with a watchdog.
- It sits between the per-channel I2S/AXI adapters and the filter engine.

Parameters:
NUM_CH, 2, number of channels (2..8)
DATA_W, 24, sample and result width
TIMEOUT, 1024, max cycles from engine sample accept to result before error

Ports:
pi_clk  in  1  clock
pi_sreset  in  1  reset, asynchronous, active-high
pi_ch_en  in  NUM_CH  per-channel enable
pi_s_tvalid  in  NUM_CH  channel input valid
pi_s_tdata  in  NUM_CH*DATA_W  channel input samples, channel c at [c*DATA_W +: DATA_W]
pi_s_tlast  in  NUM_CH  channel input last
po_s_tready  out  NUM_CH  channel input ready
po_f_tvalid  out  1  sample valid to engine
po_f_tdata  out  DATA_W  sample to engine
po_f_tlast  out  1  last to engine
pi_f_tready  in  1  engine ready for sample
po_ch_sel  out  $clog2(NUM_CH) (min 1)  coefficient bank / channel index to engine
pi_r_tvalid  in  1  engine result valid
pi_r_tdata  in  DATA_W  engine result
po_r_tready  out  1  ready for engine result
po_m_tvalid  out  NUM_CH  channel output valid
po_m_tdata  out  DATA_W  result bus shared by all channels
po_m_tlast  out  1  last flag of delivered result
pi_m_tready  in  NUM_CH  channel output ready
po_busy  out  1  state != IDLE
po_err  out  1  one-cycle pulse on watchdog expiry
po_err_ch  out  $clog2(NUM_CH)  channel of last timeout, held until next error

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, all hold_valid=0, rr_ptr=0, cur_ch=0, watchdog=0. All outputs 0, including po_s_tready, po_ch_sel and po_err_ch. Reset mid-transaction drops buffered and in-flight samples; the engine shares the same reset.
- Input buffer per channel: one-entry register {data, last}.
  - po_s_tready[c] = pi_ch_en[c] && !hold_valid[c] (registered state, no combinational path from tvalid).
  - Accept on tvalid && tready.
  - Deasserting pi_ch_en keeps any held sample, which is still scheduled.
- FSM states: IDLE, ARB, ISSUE, WAIT_RES, DELIVER.
- IDLE: when any hold_valid is set, go to ARB next cycle.
- ARB: one cycle. Grant the first c with hold_valid, searching rr_ptr, rr_ptr+1, … mod NUM_CH. Register cur_ch and po_ch_sel, go to ISSUE. If nothing is pending, go to IDLE.
- ISSUE:
  - Drive po_f_tvalid=1, po_f_tdata=hold_data[cur_ch], po_f_tlast=hold_last[cur_ch]. po_ch_sel stays stable from ARB through DELIVER.
  - On pi_f_tready: clear hold_valid[cur_ch], capture last_flag, clear watchdog, go to WAIT_RES.
  - No timeout in ISSUE; the engine may stall indefinitely.
- WAIT_RES:
  - po_r_tready=1.
  - On pi_r_tvalid: capture pi_r_tdata into the output register, go to DELIVER.
  - Otherwise increment watchdog. When it reaches TIMEOUT-1 without a result: pulse po_err, set po_err_ch=cur_ch, set rr_ptr=cur_ch+1 mod NUM_CH, go to ARB. The sample is dropped.
  - A result arriving in the same cycle as expiry takes precedence: no error.
- DELIVER:
  - po_m_tvalid[cur_ch]=1, all other bits 0. po_m_tdata = captured result, po_m_tlast = last_flag.
  - On pi_m_tready[cur_ch]: rr_ptr = cur_ch+1 (wrap to 0 at NUM_CH), go to ARB.
  - Results are never dropped; backpressure holds the FSM here.
- Results outside WAIT_RES are ignored (po_r_tready=0).
- Minimum latency, input accept to po_m_tvalid: 3 cycles plus engine latency (IDLE → ARB → ISSUE → WAIT_RES → DELIVER).
- Fairness: after a grant to c, every other pending channel is served before c again.
- Only the granted channel's buffer is cleared, so new samples on other channels are accepted in any state.

Decomposition:
- Package filter_sched_pkg: state enum sched_state_t (logic [2:0]), function rr_pick(pending, ptr) returning the next grant index plus a found flag.
- One sub-module is natural: chan_in_buf, the single-entry per-channel holding register, instantiated NUM_CH times via generate.

Test Plan:
- NUM_CH=2, ch0 sends 0x000123. Engine ready and answers 0x000456 after 5 cycles → po_f_tdata=0x000123 with po_ch_sel=0, then po_m_tvalid=2'b01 with po_m_tdata=0x000456. First valid occurs 8 cycles after accept.
- Both channels pending at reset release → grant order ch0, ch1, ch0, ch1 over 4 samples per channel. po_ch_sel toggles each transaction.
- Engine never returns a result, TIMEOUT=16 → po_err pulses once, 16 cycles after the engine accepts. po_err_ch=cur_ch, the FSM returns to ARB, and the next channel is served normally.
- pi_m_tready[0] held low 20 cycles in DELIVER → po_m_tvalid stays 01 with stable data. Meanwhile ch1 input is accepted (po_s_tready[1] drops to 0 after accept), and ch1 is served once ch0 completes.
- pi_ch_en=2'b10 → po_s_tready[0]=0 throughout and ch0 is never granted. ch1 tlast=1 propagates to po_f_tlast and po_m_tlast.
- Assert pi_sreset asynchronously mid-WAIT_RES → all outputs 0 immediately, hold buffers empty. After release, the FSM is in IDLE and po_busy=0.
